pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255: max data-memory wait cycles before timeout error.
REQ-002 SHALL use data_ctrl encoding DATA_CTRL_NORMAL=2'b00, DATA_CTRL_FLUSH=2'b01, DATA_CTRL_STOP=2'b10; 2'b11 is never driven.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 id_rs1_i, id_rs2_i  in  5 each  ID-stage source register indices.
REQ-006 id_re1_i, id_re2_i  in  1 each  ID-stage source read enables.
REQ-007 ex_wR_i  in  5  EX-stage destination index; ex_load_i  in  1  EX instruction is a load.
REQ-008 ex_jump_i  in  1  branch/jump taken, resolved in EX.
REQ-009 mem_req_i, mem_ack_i  in  1 each  data-memory request from MEM stage and completion.
REQ-010 pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o  out  2 each  data_ctrl to PC and pipeline registers.
REQ-011 mem_err_o  out  1  sticky memory-timeout error.

Function
REQ-012 Control outputs SHALL be combinational from current inputs and FSM state; same-cycle effect at next edge.
REQ-013 FSM states: RUN, MEM_WAIT, REDIRECT.
REQ-014 Load-use hazard = ex_load_i & ex_wR_i!=0 & ((id_re1_i & id_rs1_i==ex_wR_i) | (id_re2_i & id_rs2_i==ex_wR_i)).
REQ-015 Priority, highest first: memory wait, taken jump, load-use, normal.
REQ-016 Memory wait (mem_req_i & ~mem_ack_i, any state): pc, if_id, id_ex, ex_mem = STOP; mem_wb = FLUSH; next state MEM_WAIT.
REQ-017 MEM_WAIT SHALL persist while mem_ack_i=0; on mem_ack_i=1, outputs NORMAL that cycle, next state RUN.
REQ-018 Taken jump (no memory wait): pc = NORMAL (loads target), if_id = FLUSH, id_ex = FLUSH, others NORMAL; next state REDIRECT.
REQ-019 REDIRECT lasts exactly one cycle, SHALL suppress load-use detection, then returns to RUN; jump in REDIRECT re-enters REDIRECT.
REQ-020 Load-use in RUN: pc = STOP, if_id = STOP, id_ex = FLUSH, ex_mem and mem_wb NORMAL; state stays RUN (bubble clears hazard next cycle).
REQ-021 Otherwise all outputs NORMAL.
REQ-022 8-bit wait counter SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle, saturate at 255.
REQ-023 Counter reaching WAIT_TIMEOUT SHALL set mem_err_o; it stays set until reset; stalling continues.
REQ-024 Jump and memory wait in same cycle: memory wait wins; jump is held in EX (ex_mem STOP) and acted on after ack.

Reset
REQ-025 rst_n_i=0 SHALL immediately force state RUN, wait counter 0, mem_err_o 0, stall/flush counters 0.
REQ-026 During reset all ctrl outputs SHALL be DATA_CTRL_FLUSH; after release, first cycle NORMAL unless a hazard is present.
REQ-027 Reset mid-MEM_WAIT SHALL abandon the wait without asserting mem_err_o.

Configuration
REQ-028 Macro PIPELINE_CTRL_PERF_EN defined: add outputs stall_cnt_o[31:0] (cycles with pc_ctrl_o=STOP) and flush_cnt_o[31:0] (taken-jump cycles), both saturating at 32'hFFFFFFFF.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 ex_load_i=1, ex_wR_i=5, id_re1_i=1, id_rs1_i=5 -> pc/if_id STOP, id_ex FLUSH one cycle; next cycle all NORMAL.
REQ-031 Same as REQ-030 but ex_wR_i=0 -> all NORMAL.
REQ-032 ex_jump_i=1 one cycle -> if_id/id_ex FLUSH; next cycle load-use pattern present -> outputs NORMAL (REDIRECT suppression).
REQ-033 mem_req_i=1, mem_ack_i=0 for 3 cycles then ack -> 3 cycles STOP with mem_wb FLUSH, ack cycle NORMAL, mem_err_o=0.
REQ-034 WAIT_TIMEOUT=4, mem_ack_i held 0 for 10 cycles -> mem_err_o rises after 4th wait cycle, stays 1 after ack; rst_n_i=0 clears it.
REQ-035 With PIPELINE_CTRL_PERF_EN: two load-use stalls + one jump -> stall_cnt_o=2, flush_cnt_o=1.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and data_ctrl outputs exchanged between
// the pipeline datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_re1_i;
    logic       id_re2_i;
    logic [4:0] ex_wR_i;
    logic       ex_load_i;
    logic       ex_jump_i;
    logic       mem_req_i;
    logic       mem_ack_i;
    logic [1:0] pc_ctrl_o;
    logic [1:0] if_id_ctrl_o;
    logic [1:0] id_ex_ctrl_o;
    logic [1:0] ex_mem_ctrl_o;
    logic [1:0] mem_wb_ctrl_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_re1_i, id_re2_i,
        output ex_wR_i, ex_load_i, ex_jump_i,
        output mem_req_i, mem_ack_i,
        input  pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o,
        input  ex_mem_ctrl_o, mem_wb_ctrl_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_re1_i, id_re2_i,
        input  ex_wR_i, ex_load_i, ex_jump_i,
        input  mem_req_i, mem_ack_i,
        output pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o,
        output ex_mem_ctrl_o, mem_wb_ctrl_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait timeout.
// Define PIPELINE_CTRL_PERF_EN to add stall/flush counters.
module pipeline_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    pipeline_ctrl_if.slave bus,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
`endif
    output logic mem_err_o
);
    localparam logic [1:0] NORMAL = 2'b00;
    localparam logic [1:0] FLUSH  = 2'b01;
    localparam logic [1:0] STOP   = 2'b10;

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic       mem_wait;
    logic       jump_act;
    logic       hit1;
    logic       hit2;
    logic       load_use;

    assign mem_wait = bus.mem_req_i & ~bus.mem_ack_i;
    assign jump_act = bus.ex_jump_i & ~mem_wait;
    assign hit1 = bus.id_re1_i & (bus.id_rs1_i == bus.ex_wR_i);
    assign hit2 = bus.id_re2_i & (bus.id_rs2_i == bus.ex_wR_i);
    assign load_use = bus.ex_load_i & (bus.ex_wR_i != 5'd0)
                    & (hit1 | hit2);

    always_comb begin
        bus.pc_ctrl_o     = NORMAL;
        bus.if_id_ctrl_o  = NORMAL;
        bus.id_ex_ctrl_o  = NORMAL;
        bus.ex_mem_ctrl_o = NORMAL;
        bus.mem_wb_ctrl_o = NORMAL;
        state_nxt         = RUN;
        if (!rst_n_i) begin
            bus.pc_ctrl_o     = FLUSH;
            bus.if_id_ctrl_o  = FLUSH;
            bus.id_ex_ctrl_o  = FLUSH;
            bus.ex_mem_ctrl_o = FLUSH;
            bus.mem_wb_ctrl_o = FLUSH;
        end else if (mem_wait) begin
            bus.pc_ctrl_o     = STOP;
            bus.if_id_ctrl_o  = STOP;
            bus.id_ex_ctrl_o  = STOP;
            bus.ex_mem_ctrl_o = STOP;
            bus.mem_wb_ctrl_o = FLUSH;
            state_nxt         = MEM_WAIT;
        end else if (bus.ex_jump_i) begin
            bus.if_id_ctrl_o = FLUSH;
            bus.id_ex_ctrl_o = FLUSH;
            state_nxt        = REDIRECT;
        end else if (load_use && state != REDIRECT) begin
            bus.pc_ctrl_o    = STOP;
            bus.if_id_ctrl_o = STOP;
            bus.id_ex_ctrl_o = FLUSH;
        end
    end

    // The entry cycle already counts as the first wait cycle.
    always_comb begin
        if (state != MEM_WAIT)
            wait_nxt = 8'd1;
        else if (wait_cnt == 8'hFF)
            wait_nxt = 8'hFF;
        else
            wait_nxt = wait_cnt + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mem_wait) begin
                wait_cnt <= wait_nxt;
                if ({24'd0, wait_nxt} >= WAIT_TIMEOUT)
                    mem_err_o <= 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (bus.pc_ctrl_o == STOP && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (jump_act && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`else
    logic unused_jump;
    assign unused_jump = jump_act;
`endif
endmodule
